// File: rtl/demux8_collector.sv
// Eight-slot collector: steers one WIDTH-bit word per handshake into y1..y8 and
// presents a held frame once all slots fill. Optional macro DEMUX_AUTO_INC_EN.
module demux8_collector #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   input  logic             s0,
   input  logic             s1,
   input  logic             s2,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] y1,
   output logic [WIDTH-1:0] y2,
   output logic [WIDTH-1:0] y3,
   output logic [WIDTH-1:0] y4,
   output logic [WIDTH-1:0] y5,
   output logic [WIDTH-1:0] y6,
   output logic [WIDTH-1:0] y7,
   output logic [WIDTH-1:0] y8,
   output logic [7:0]       slot_vld,
   output logic [3:0]       fill_cnt,
   output logic             frame_valid,
   input  logic             frame_ack
);

   localparam int unsigned NSLOT = 8;

   typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_e;

   state_e                       state_q, state_d;
   logic [NSLOT-1:0][WIDTH-1:0]  y_q, y_d;
   logic [NSLOT-1:0]             slot_vld_q, slot_vld_d;
   logic [3:0]                   fill_cnt_q, fill_cnt_d;
   logic                         frame_valid_q, frame_valid_d;
   logic [2:0]                   sel;
   logic                         wr_en;

`ifdef DEMUX_AUTO_INC_EN
   // Write pointer replaces the select ports; its target is always empty in FILL.
   logic [2:0] ptr_q, ptr_d;
   logic       unused_sel;

   assign unused_sel = s0 ^ s1 ^ s2;
   assign sel        = ptr_q;
   assign in_ready   = (state_q == FILL);
   assign ptr_d      = wr_en ? 3'(ptr_q + 3'd1) : ptr_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end
`else
   assign sel      = {s2, s1, s0};
   assign in_ready = (state_q == FILL) && !slot_vld_q[sel];
`endif

   assign wr_en = in_valid && in_ready;

   // Next-state: accept writes in FILL, clear flags on ack in FULL.
   always_comb begin
      state_d       = state_q;
      y_d           = y_q;
      slot_vld_d    = slot_vld_q;
      fill_cnt_d    = fill_cnt_q;
      frame_valid_d = frame_valid_q;
      case (state_q)
         FILL: begin
            if (wr_en) begin
               y_d[sel]        = d;
               slot_vld_d[sel] = 1'b1;
               fill_cnt_d      = 4'(fill_cnt_q + 4'd1);
               if (fill_cnt_q == 4'd7) begin
                  state_d       = FULL;
                  frame_valid_d = 1'b1;
               end
            end
         end
         FULL: begin
            if (frame_ack) begin
               state_d       = FILL;
               slot_vld_d    = '0;
               fill_cnt_d    = '0;
               frame_valid_d = 1'b0;
            end
         end
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= FILL;
         y_q           <= '0;
         slot_vld_q    <= '0;
         fill_cnt_q    <= '0;
         frame_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         y_q           <= y_d;
         slot_vld_q    <= slot_vld_d;
         fill_cnt_q    <= fill_cnt_d;
         frame_valid_q <= frame_valid_d;
      end
   end

   assign y1          = y_q[0];
   assign y2          = y_q[1];
   assign y3          = y_q[2];
   assign y4          = y_q[3];
   assign y5          = y_q[4];
   assign y6          = y_q[5];
   assign y7          = y_q[6];
   assign y8          = y_q[7];
   assign slot_vld    = slot_vld_q;
   assign fill_cnt    = fill_cnt_q;
   assign frame_valid = frame_valid_q;

endmodule

// File: tb/tb_demux8_collector.sv
// Self-checking bench for demux8_collector: vector table, corner sequences and
// random traffic against a slot-array reference model.
module tb_demux8_collector;

   logic       clk, rst;
   logic [3:0] d;
   logic       s0, s1, s2, in_valid, in_ready, frame_ack, frame_valid;
   logic [3:0] y1, y2, y3, y4, y5, y6, y7, y8;
   logic [7:0] slot_vld;
   logic [3:0] fill_cnt;
   logic [3:0] y_dut [8];

   int checks = 0;
   int errors = 0;

   // Reference model: slot contents, fresh flags, full flag, auto pointer.
   logic [3:0] m_y [8];
   bit         m_vld [8];
   bit         m_full;
   int         m_ptr;

   demux8_collector #(.WIDTH(4)) dut (
      .clk(clk), .rst(rst), .d(d), .s0(s0), .s1(s1), .s2(s2),
      .in_valid(in_valid), .in_ready(in_ready),
      .y1(y1), .y2(y2), .y3(y3), .y4(y4), .y5(y5), .y6(y6), .y7(y7), .y8(y8),
      .slot_vld(slot_vld), .fill_cnt(fill_cnt), .frame_valid(frame_valid),
      .frame_ack(frame_ack)
   );

   assign y_dut[0] = y1;
   assign y_dut[1] = y2;
   assign y_dut[2] = y3;
   assign y_dut[3] = y4;
   assign y_dut[4] = y5;
   assign y_dut[5] = y6;
   assign y_dut[6] = y7;
   assign y_dut[7] = y8;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int m_target(input logic [2:0] s);
`ifdef DEMUX_AUTO_INC_EN
      return m_ptr;
`else
      return int'(s);
`endif
   endfunction

   function automatic bit m_ready(input logic [2:0] s);
      return !m_full && !m_vld[m_target(s)];
   endfunction

   function automatic int m_count();
      int n = 0;
      for (int k = 0; k < 8; k++) n += int'(m_vld[k]);
      return n;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 8; k++) begin
         m_y[k]   = '0;
         m_vld[k] = 1'b0;
      end
      m_full = 1'b0;
      m_ptr  = 0;
   endtask

   task automatic model_step(input logic v, input logic [2:0] s, input logic [3:0] dd, input logic a);
      int t;
      if (m_full) begin
         if (a) begin
            m_full = 1'b0;
            for (int k = 0; k < 8; k++) m_vld[k] = 1'b0;
         end
      end else if (v && m_ready(s)) begin
         t        = m_target(s);
         m_y[t]   = dd;
         m_vld[t] = 1'b1;
         m_ptr    = (m_ptr + 1) % 8;
         if (m_count() == 8) m_full = 1'b1;
      end
   endtask

   task automatic check_all();
      logic [7:0] vv;
      for (int k = 0; k < 8; k++) begin
         vv[k] = m_vld[k];
         chk($sformatf("y%0d", k + 1), 32'(y_dut[k]), 32'(m_y[k]));
      end
      chk("slot_vld", 32'(slot_vld), 32'(vv));
      chk("fill_cnt", 32'(fill_cnt), 32'(m_count()));
      chk("frame_valid", 32'(frame_valid), 32'(m_full));
   endtask

   // One clock: drive, check in_ready before the edge, step model, check after.
   task automatic cycle(input logic v, input logic [2:0] s, input logic [3:0] dd,
                        input logic a, output logic rdy);
      in_valid = v; {s2, s1, s0} = s; d = dd; frame_ack = a;
      #1;
      rdy = in_ready;
      chk("in_ready", 32'(in_ready), 32'(m_ready(s)));
      @(posedge clk);
      model_step(v, s, dd, a);
      #1;
      check_all();
   endtask

   task automatic idle();
      logic r;
      cycle(1'b0, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 1'b0, r);
   endtask

   task automatic do_reset();
      in_valid = 1'b0; frame_ack = 1'b0;
      rst = 1'b1;
      #1;
      model_reset();
      check_all();
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("ready_after_reset", 32'(in_ready), 32'd1);
   endtask

   typedef struct {
      logic       v;
      logic [2:0] s;
      logic [3:0] d;
      logic       a;
      logic       e_rdy;
      logic [3:0] e_fill;
      logic       e_fv;
      logic [3:0] e_y1;
   } vec_t;

   vec_t tbl [11];

   initial begin
      logic r;
      rst = 1'b1; d = '0; {s2, s1, s0} = 3'd0; in_valid = 1'b0; frame_ack = 1'b0;
      model_reset();

      // In-order fill, then ack colliding with a write, then the retry.
      for (int i = 0; i < 8; i++)
         tbl[i] = '{1'b1, 3'(i), 4'(i + 1), 1'b0, 1'b1, 4'(i + 1), (i == 7), 4'd1};
      tbl[8]  = '{1'b1, 3'd0, 4'hE, 1'b0, 1'b0, 4'd8, 1'b1, 4'd1};
      tbl[9]  = '{1'b1, 3'd0, 4'hF, 1'b1, 1'b0, 4'd0, 1'b0, 4'd1};
      tbl[10] = '{1'b1, 3'd0, 4'hF, 1'b0, 1'b1, 4'd1, 1'b0, 4'hF};

      do_reset();
      for (int i = 0; i < 11; i++) begin
         cycle(tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].a, r);
         chk($sformatf("tbl%0d_ready", i), 32'(r), 32'(tbl[i].e_rdy));
         chk($sformatf("tbl%0d_fill", i), 32'(fill_cnt), 32'(tbl[i].e_fill));
         chk($sformatf("tbl%0d_fv", i), 32'(frame_valid), 32'(tbl[i].e_fv));
         chk($sformatf("tbl%0d_y1", i), 32'(y1), 32'(tbl[i].e_y1));
         if (i == 7)
            for (int k = 1; k < 8; k++)
               chk($sformatf("inorder_y%0d", k + 1), 32'(y_dut[k]), 32'(k + 1));
      end

      // Asynchronous reset mid-frame.
      do_reset();
      for (int i = 0; i < 5; i++) cycle(1'b1, 3'(i), 4'(i + 3), 1'b0, r);
      #2;
      rst = 1'b1;
      #1;
      chk("async_fill", 32'(fill_cnt), 32'd0);
      chk("async_vld", 32'(slot_vld), 32'd0);
      chk("async_y1", 32'(y1), 32'd0);
      chk("async_y5", 32'(y5), 32'd0);
      model_reset();
      #2;
      rst = 1'b0;
      #1;
      chk("async_rel_fill", 32'(fill_cnt), 32'd0);
      chk("async_rel_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;

`ifndef DEMUX_AUTO_INC_EN
      // Duplicate-slot stall.
      do_reset();
      cycle(1'b1, 3'd3, 4'hA, 1'b0, r);
      cycle(1'b1, 3'd3, 4'h5, 1'b0, r);
      chk("dup_ready", 32'(r), 32'd0);
      chk("dup_y4", 32'(y4), 32'hA);
      cycle(1'b1, 3'd4, 4'h5, 1'b0, r);
      chk("dup_alt_ready", 32'(r), 32'd1);
      chk("dup_y5", 32'(y5), 32'h5);

      // Out-of-order fill with idle gaps and an early (ignored) ack.
      begin
         int order [8] = '{7, 2, 0, 5, 1, 6, 3, 4};
         do_reset();
         for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 2)) idle();
            if (i == 3) begin
               cycle(1'b0, 3'd0, 4'd0, 1'b1, r);
               chk("early_ack_fill", 32'(fill_cnt), 32'd3);
            end
            chk($sformatf("ooo_fv_before%0d", i), 32'(frame_valid), 32'd0);
            cycle(1'b1, 3'(order[i]), 4'(order[i]) ^ 4'h9, 1'b0, r);
         end
         chk("ooo_fv", 32'(frame_valid), 32'd1);
         for (int k = 0; k < 8; k++)
            chk($sformatf("ooo_y%0d", k + 1), 32'(y_dut[k]), 32'(4'(k) ^ 4'h9));
         cycle(1'b0, 3'd0, 4'd0, 1'b1, r);
      end
`else
      // Auto-increment: select ports parked at 7, ten words with an ack after eight.
      do_reset();
      for (int i = 0; i < 8; i++) cycle(1'b1, 3'd7, 4'(i), 1'b0, r);
      chk("auto_fv", 32'(frame_valid), 32'd1);
      for (int k = 0; k < 8; k++)
         chk($sformatf("auto_y%0d", k + 1), 32'(y_dut[k]), 32'(k));
      cycle(1'b0, 3'd7, 4'd0, 1'b1, r);
      cycle(1'b1, 3'd7, 4'd8, 1'b0, r);
      cycle(1'b1, 3'd7, 4'd9, 1'b0, r);
      chk("auto_y1", 32'(y1), 32'd8);
      chk("auto_y2", 32'(y2), 32'd9);
      chk("auto_ptr_vld", 32'(slot_vld), 32'h03);
`endif

      // Random traffic against the model.
      do_reset();
      for (int i = 0; i < 1500; i++)
         cycle($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
               4'($urandom_range(0, 15)), $urandom_range(0, 5) == 0, r);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/demux8_collector.md
Name: demux8_collector

Overview:
- Inverse counterpart of the 8:1 nibble multiplexer.
- Accepts one WIDTH-bit word per handshake on a single input and steers it into one of eight registered output slots y1..y8, chosen by select lines s2,s1,s0.
- Tracks which slots hold fresh data, declares a complete frame once all eight are filled, and holds the frame stable until the consumer acknowledges it.
- Sits between a serial nibble source and any block that consumes eight parallel nibbles, such as the 8:1 mux's y1..y8 inputs.

Parameters:
- WIDTH, 4, data width of the input word and of each output slot.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- d  input  WIDTH  input data word.
- s0  input  1  slot select bit 0.
- s1  input  1  slot select bit 1.
- s2  input  1  slot select bit 2.
- in_valid  input  1  d and select lines are valid this cycle.
- in_ready  output  1  block can accept a write this cycle.
- y1..y8  output  WIDTH each  registered slot contents.
- slot_vld  output  8  bit k-1 set means slot yk has been written since the last clear.
- fill_cnt  output  4  number of filled slots, 0..8.
- frame_valid  output  1  all eight slots filled; frame held stable.
- frame_ack  input  1  consumer has taken the frame; clears all slot flags.

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: y1..y8=0, slot_vld=0, fill_cnt=0, frame_valid=0, state=FILL.
  - in_ready evaluates to 1 while rst is low after release.
  - Assertion of rst mid-frame discards all partial data immediately, without waiting for a clock edge.
- Slot select: sel={s2,s1,s0}. sel=0 selects y1 … sel=7 selects y8, the same mapping as the 8:1 mux.
- Write acceptance: a write occurs on a rising clk when in_valid && in_ready.
  - The targeted yk takes d at that edge.
  - slot_vld[sel] is set and fill_cnt increments by 1.
  - Latency is 1 cycle: yk updates on the edge after acceptance.
- in_ready is combinational from registered state and the current sel:
  - FILL state: in_ready = ~slot_vld[sel]. A write to an already-filled slot stalls; it never overwrites.
  - FULL state: in_ready = 0.
- State machine, two states:
  - FILL -> FULL on the edge where the accepted write brings fill_cnt to 8. frame_valid is asserted from the following cycle, registered.
  - FULL -> FILL on any edge with frame_ack=1. At that edge slot_vld=0, fill_cnt=0 and frame_valid=0.
  - y1..y8 keep their values after the ack; only the flags clear.
- Ignored and no-op events:
  - frame_ack in FILL is ignored: no flag change, no state change.
  - frame_ack and in_valid in the same FULL cycle: the ack is taken, the write is not accepted (in_ready=0). The source must retry the next cycle.
  - in_valid=0 means no state change regardless of d or sel.
- Stability: y1..y8 change only on accepted writes and on reset. No glitching on select changes.
- fill_cnt always equals popcount(slot_vld). It saturates at 8 by construction.

Optional Feature:
- Macro: DEMUX_AUTO_INC_EN.
- When defined:
  - s2,s1,s0 are ignored.
  - An internal 3-bit pointer supplies sel. It resets to 0, increments on every accepted write, and wraps 7->0.
  - frame_ack does not move the pointer. It is naturally 0 after each full frame.
  - in_ready = 1 in FILL, because the pointer target is always empty.
- When not defined: sel comes from the ports exactly as above, and no pointer logic is built.

Test Plan:
- Reset then in-order fill: rst pulse; write d=1..8 with sel=0..7, one per cycle.
  - Required: y1..y8 = 1..8 and fill_cnt steps 1..8.
  - frame_valid=1 the cycle after the 8th write; in_ready=0 while FULL.
- Duplicate-slot stall: write sel=3, d=A; then present sel=3, d=5 with in_valid=1.
  - Required: in_ready=0 and y4 stays A.
  - Change to sel=4: accepted, y5=5.
- Ack collision: in FULL, assert frame_ack and in_valid (sel=0, d=F) in the same cycle.
  - Required: next cycle slot_vld=0, fill_cnt=0, frame_valid=0, y1 unchanged.
  - Following cycle with sel=0, d=F: y1=F.
- Asynchronous reset mid-frame: after 5 writes, assert rst between clock edges.
  - Required: outputs go to 0 immediately, without a clock edge.
  - After release: fill_cnt=0 and in_ready=1.
- Out-of-order fill with random idle cycles: write sel order 7,2,0,5,1,6,3,4 with d=sel^4'h9.
  - Required: each yk = (k-1)^9; frame_valid asserts only after the final write.
  - A frame_ack issued earlier, while still in FILL, is ignored.
- DEMUX_AUTO_INC_EN build: select ports held at 7; write 10 words d=0..9 with an ack after the 8th.
  - Required: y1..y8 = 0..7 after the first frame.
  - After the ack, y1=8 and y2=9, and the pointer is 2.
